// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
// Provides the FSM state encoding and the default operand width.
package serial_adder_defs;

    localparam int DEFAULT_WIDTH = 8;

    // The unused code 2'd3 is treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_cell.sv
// full_adder_cell: combinational 1-bit full adder.
// Ports:
//   a, b, cin : operand bits and carry-in
//   sum, cout : sum bit and carry-out
// Functionally interchangeable with the lab's decoder-based adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract controller.
// Sequences one full_adder_cell across two WIDTH-bit operands, LSB first,
// one bit per clock, and pulses done when the result is registered.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start         : operation request, sampled only in IDLE
//   sub           : 0 = a + b + cin, 1 = a - b (sampled with start)
//   cin           : add carry-in, ignored for subtract
//   a, b          : operands (sampled with start)
//   busy          : high while bits are being processed
//   done          : one-cycle completion pulse
//   sum, cout, ovf: last completed result, carry out of MSB, signed overflow
module serial_adder_ctrl
    import serial_adder_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             load, shift, last;
    logic             cell_sum, cell_cout;

    full_adder_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        load      = 1'b0;
        shift     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                load      = start;
                state_nxt = start ? SHIFT : IDLE;
            end
            SHIFT: begin
                shift     = 1'b1;
                last      = (cnt == LAST);
                state_nxt = last ? DONE : SHIFT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            // Subtract is a + ~b + 1: invert b and force the initial carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (shift) begin
            res_sr <= {cell_sum, res_sr[WIDTH-1:1]};
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= cell_cout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                // On the MSB cycle the carry flop holds the carry into the MSB.
                sum  <= {cell_sum, res_sr[WIDTH-1:1]};
                cout <= cell_cout;
                ovf  <= carry ^ cell_cout;
            end
        end
    end

endmodule
